// File: rtl/bcd_display_mux.sv
// Two-digit BCD display multiplexer. It captures tens/units digits on load,
// then alternates the digit enables, blanking a leading zero in the tens place.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [3:0] cif_z,
  input  logic [3:0] cif_u,
  input  logic       load,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       loaded
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_U = 2'd1,
    SHOW_Z = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       z_r;
  logic [3:0]       u_r;
  logic [CNT_W-1:0] cnt_r;

  // Seven-segment decode; codes 10..15 show a lone g segment as an error dash
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Digit capture, phase counter and multiplex state; reset outranks load
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      z_r     <= 4'd0;
      u_r     <= 4'd0;
    end else if (load) begin
      state_r <= SHOW_U;
      cnt_r   <= '0;
      z_r     <= cif_z;
      u_r     <= cif_u;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
          cnt_r   <= cnt_r;
        end
        SHOW_U, SHOW_Z: begin
          if (cnt_r == CNT_MAX) begin
            cnt_r   <= '0;
            state_r <= (state_r == SHOW_U) ? SHOW_Z : SHOW_U;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Outputs depend on registered state only, never on the inputs
  always_comb begin
    an     = 2'b00;
    seg    = 7'h00;
    loaded = 1'b0;
    case (state_r)
      SHOW_U: begin
        an     = 2'b01;
        seg    = decode(u_r);
        loaded = 1'b1;
      end
      SHOW_Z: begin
        loaded = 1'b1;
        if (z_r == 4'd0) begin
          an  = 2'b00;
          seg = 7'h00;
        end else begin
          an  = 2'b10;
          seg = decode(z_r);
        end
      end
      default: begin
        an     = 2'b00;
        seg    = 7'h00;
        loaded = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed table-driven bench for bcd_display_mux with REFRESH_DIV=4, plus a
// short hand sequence on a REFRESH_DIV=1 instance sharing the same inputs.
module tb_bcd_display_mux;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [3:0] cif_z;
  logic [3:0] cif_u;
  logic       load;
  logic [1:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic       loaded4, loaded1;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bcd_display_mux #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst_b(rst_b), .cif_z(cif_z), .cif_u(cif_u), .load(load),
    .an(an4), .seg(seg4), .loaded(loaded4)
  );

  bcd_display_mux #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .cif_z(cif_z), .cif_u(cif_u), .load(load),
    .an(an1), .seg(seg1), .loaded(loaded1)
  );

  typedef struct {
    logic       rst_b;
    logic       load;
    logic [3:0] z;
    logic [3:0] u;
    logic [1:0] an;
    logic [6:0] seg;
    logic       loaded;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic l, input logic [3:0] z,
                     input logic [3:0] u, input logic [1:0] a, input logic [6:0] s,
                     input logic ld);
    vec_t v;
    v.rst_b = r; v.load = l; v.z = z; v.u = u;
    v.an = a; v.seg = s; v.loaded = ld;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] z, input logic [3:0] u);
    rst_b = r; load = l; cif_z = z; cif_u = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0; load = 1'b0; cif_z = 4'd0; cif_u = 4'd0;

    // reset with load toggling, then idle holds without load
    add(1, 1'b0, 1'b1, 4'd3, 4'd4, 2'b00, 7'h00, 1'b0);
    add(1, 1'b0, 1'b0, 4'd3, 4'd4, 2'b00, 7'h00, 1'b0);
    add(2, 1'b1, 1'b0, 4'd3, 4'd4, 2'b00, 7'h00, 1'b0);
    // 15: units 4 cycles, tens 4 cycles, units again
    add(1, 1'b1, 1'b1, 4'd1, 4'd5, 2'b01, 7'h6D, 1'b1);
    add(3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h6D, 1'b1);
    add(4, 1'b1, 1'b0, 4'd0, 4'd0, 2'b10, 7'h06, 1'b1);
    add(1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h6D, 1'b1);
    // 07: tens blanked for a full phase, loaded stays high
    add(1, 1'b1, 1'b1, 4'd0, 4'd7, 2'b01, 7'h07, 1'b1);
    add(3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h07, 1'b1);
    add(4, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 7'h00, 1'b1);
    add(1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h07, 1'b1);
    // out-of-range tens digit 12
    add(1, 1'b1, 1'b1, 4'd12, 4'd3, 2'b01, 7'h4F, 1'b1);
    add(3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h4F, 1'b1);
    add(2, 1'b1, 1'b0, 4'd0, 4'd0, 2'b10, 7'h40, 1'b1);
    // 18, then reload 09 on the 2nd tens cycle
    add(1, 1'b1, 1'b1, 4'd1, 4'd8, 2'b01, 7'h7F, 1'b1);
    add(3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h7F, 1'b1);
    add(1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b10, 7'h06, 1'b1);
    add(1, 1'b1, 1'b1, 4'd0, 4'd9, 2'b01, 7'h6F, 1'b1);
    add(3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h6F, 1'b1);
    add(1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 7'h00, 1'b1);
    // identical reload mid-units restarts the count
    add(1, 1'b1, 1'b1, 4'd0, 4'd9, 2'b01, 7'h6F, 1'b1);
    add(1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h6F, 1'b1);
    add(1, 1'b1, 1'b1, 4'd0, 4'd9, 2'b01, 7'h6F, 1'b1);
    add(3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h6F, 1'b1);
    add(1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 7'h00, 1'b1);
    // back-to-back loads: last one wins
    add(1, 1'b1, 1'b1, 4'd2, 4'd1, 2'b01, 7'h06, 1'b1);
    add(1, 1'b1, 1'b1, 4'd3, 4'd4, 2'b01, 7'h66, 1'b1);
    add(3, 1'b1, 1'b0, 4'd0, 4'd0, 2'b01, 7'h66, 1'b1);
    add(1, 1'b1, 1'b0, 4'd0, 4'd0, 2'b10, 7'h4F, 1'b1);
    // reset beats a simultaneous load during units
    add(1, 1'b1, 1'b1, 4'd6, 4'd2, 2'b01, 7'h5B, 1'b1);
    add(1, 1'b0, 1'b1, 4'd5, 4'd5, 2'b00, 7'h00, 1'b0);
    add(2, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 7'h00, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_b, vecs[i].load, vecs[i].z, vecs[i].u);
      check("an", i, {6'd0, an4}, {6'd0, vecs[i].an});
      check("seg", i, {1'b0, seg4}, {1'b0, vecs[i].seg});
      check("loaded", i, {7'd0, loaded4}, {7'd0, vecs[i].loaded});
    end

    // REFRESH_DIV=1: digits alternate every cycle
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    check("div1_rst_an", 0, {6'd0, an1}, 8'h00);
    check("div1_rst_loaded", 0, {7'd0, loaded1}, 8'h00);
    drive(1'b1, 1'b1, 4'd1, 4'd5);
    check("div1_an", 1, {6'd0, an1}, 8'h01);
    check("div1_seg", 1, {1'b0, seg1}, 8'h6D);
    check("div1_loaded", 1, {7'd0, loaded1}, 8'h01);
    drive(1'b1, 1'b0, 4'd0, 4'd0);
    check("div1_an", 2, {6'd0, an1}, 8'h02);
    check("div1_seg", 2, {1'b0, seg1}, 8'h06);
    drive(1'b1, 1'b0, 4'd0, 4'd0);
    check("div1_an", 3, {6'd0, an1}, 8'h01);
    check("div1_seg", 3, {1'b0, seg1}, 8'h6D);
    drive(1'b1, 1'b0, 4'd0, 4'd0);
    check("div1_an", 4, {6'd0, an1}, 8'h02);
    check("div4_an", 4, {6'd0, an4}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter: REFRESH_DIV, 4, clock cycles each digit is shown per multiplex phase; legal range 1..65535.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_b  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 cif_z  input  4  tens BCD digit from the adder stage.
REQ-006 cif_u  input  4  units BCD digit from the adder stage.
REQ-007 load  input  1  single-cycle strobe; cif_z/cif_u are captured on the edge where load=1.
REQ-008 an  output  2  one-hot active-high digit enable: an[0] is units, an[1] is tens.
REQ-009 seg  output  7  active-high segments, bit0=a .. bit6=g.
REQ-010 loaded  output  1  high once a value has been captured since reset.

Function
REQ-011 State SHALL be held in registers z_r[3:0], u_r[3:0], cnt (width max(1,clog2(REFRESH_DIV))), and a state machine with states IDLE, SHOW_U and SHOW_Z.
REQ-012 an, seg and loaded SHALL be combinational decodes of the registered state only, with no path from any input to any output.
REQ-013 IDLE: an=00, seg=0000000, loaded=0; the block SHALL leave IDLE only on load.
REQ-014 load=1 in any state: on that edge z_r<=cif_z, u_r<=cif_u, cnt<=0, state<=SHOW_U.
REQ-015 In SHOW_U/SHOW_Z with load=0: if cnt==REFRESH_DIV-1, then cnt<=0 and the state toggles SHOW_U<->SHOW_Z; otherwise cnt<=cnt+1.
REQ-016 Each digit phase SHALL last exactly REFRESH_DIV cycles.
REQ-017 With REFRESH_DIV=1 the state SHALL toggle every cycle.
REQ-018 SHOW_U: an=01, seg=decode(u_r).
REQ-019 SHOW_Z: an=10, seg=decode(z_r).
REQ-020 Exception (leading-zero blanking): SHOW_Z with z_r==0 SHALL drive an=00 and seg=0000000, and the phase still lasts REFRESH_DIV cycles.
REQ-021 decode SHALL map 0..9 to hex 3F,06,5B,4F,66,6D,7D,07,7F,6F.
REQ-022 decode of any value 10..15 SHALL give 40 (segment g only, error dash).
REQ-023 loaded SHALL be 1 in SHOW_U and SHOW_Z.
REQ-024 A load arriving mid-phase SHALL abort the phase, and the new value SHALL always start in SHOW_U.
REQ-025 Consecutive loads SHALL each be captured, and the last one wins.
REQ-026 A load with identical digits SHALL still restart cnt and the phase.

Reset
REQ-027 While rst_b=0 at a clk edge, the block SHALL set state<=IDLE, cnt<=0, z_r<=0 and u_r<=0.
REQ-028 Reset outputs: an=00, seg=0000000, loaded=0.
REQ-029 rst_b=0 SHALL take priority over a simultaneous load=1; that load value is discarded.
REQ-030 Reset SHALL be honoured in any state and at any cnt value; there is no asynchronous path.

Verification (REFRESH_DIV=4 unless noted)
REQ-031 Reset: rst_b=0 for 2 edges with load toggling -> an=00, seg=00, loaded=0 after the first edge.
REQ-032 Two-digit value: load with z=1, u=5 -> an=01/seg=6D for 4 cycles, then an=10/seg=06 for 4 cycles, repeating; loaded=1.
REQ-033 Leading-zero blanking: load z=0, u=7 -> units phase an=01/seg=07 for 4 cycles, then an=00/seg=00 for 4 cycles.
REQ-034 Out-of-range digit: load z=12, u=3 -> units seg=4F, tens seg=40.
REQ-035 Reload mid-phase: load z=1, u=8, then load z=0, u=9 on the 2nd cycle of SHOW_Z -> next cycle an=01/seg=6F, with a full 4-cycle units phase.
REQ-036 Reset mid-operation and edge cases: rst_b=0 together with load=1 during SHOW_U -> IDLE next cycle, values discarded; repeat the REQ-032 case with REFRESH_DIV=1 -> an alternates 01/10 every cycle.
